hazard_ctrl: RTL and testbench

Pipeline hazard and control-flow sequencer for the 5-stage CPU. It sits beside the ID stage and tracks in-flight register writers in a scoreboard. From that scoreboard and the branch/jump resolution in EX it drives PC enable, IF/ID write/flush and ID/EX bubble insertion. It also keeps a saturating stall counter for performance debug.

---
 rtl/hazard_ctrl_pkg.sv | 37 +++
 rtl/hazard_ctrl_if.sv | 50 +++++
 rtl/hazard_scoreboard.sv | 70 +++++++
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the hazard/control-flow
// sequencer. Optional feature macro used by this block: FORWARD_EN.
package hazard_ctrl_pkg;

  localparam int REG_AW_DEF     = 6;
  localparam int PIPE_DEPTH_DEF = 3;
  localparam int CNT_W_DEF      = 16;
  // Scoreboard rd field is sized for the widest supported register address;
  // narrower REG_AW values are zero-extended into it.
  localparam int REG_AW_MAX     = 8;

  typedef enum logic {
    RUN    = 1'b0,
    JMWAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic                  v;   // entry holds a real register writer
    logic [REG_AW_MAX-1:0] rd;  // destination register
    logic                  ld;  // writer is a load
  } sb_entry_t;

  // Control-flow redirect resolved in EX this cycle.
  function automatic logic calc_taken(
    input logic ex_valid,
    input logic ex_branch_z,
    input logic ex_branch_n,
    input logic ex_jump,
    input logic ex_jump_m,
    input logic ex_zero,
    input logic ex_neg
  );
    return ex_valid & ((ex_branch_z & ex_zero) | (ex_branch_n & ex_neg) |
                       ex_jump | ex_jump_m);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX observation inputs and pipeline control outputs of
// the hazard sequencer. master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  // ID stage instruction
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  // EX stage control-flow resolution
  logic              ex_valid;
  logic              ex_branch_z;
  logic              ex_branch_n;
  logic              ex_jump;
  logic              ex_jump_m;
  logic              ex_zero;
  logic              ex_neg;
  // pipeline control
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_reg_write, id_mem_read,
           ex_valid, ex_branch_z, ex_branch_n, ex_jump, ex_jump_m,
           ex_zero, ex_neg,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_reg_write, id_mem_read,
           ex_valid, ex_branch_z, ex_branch_n, ex_jump, ex_jump_m,
           ex_zero, ex_neg,
    output pc_write, ifid_write, ifid_flush, idex_bubble, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift register of in-flight register writers
// (entry 0 = EX, then MEM, WB) and RAW hazard detection for the ID
// instruction. FORWARD_EN restricts the hazard to load-use on entry 0.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,        // ID instruction moves into EX
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  output logic              hazard
);

  if (REG_AW > REG_AW_MAX) begin : g_aw_chk
    $error("hazard_scoreboard: REG_AW exceeds REG_AW_MAX");
  end

  sb_entry_t [PIPE_DEPTH-1:0] sb;
  sb_entry_t                  sb_new;
  logic      [PIPE_DEPTH-1:0] match;
  logic      [REG_AW_MAX-1:0] rs_x, rt_x;

  assign rs_x = REG_AW_MAX'(id_rs);
  assign rt_x = REG_AW_MAX'(id_rt);

  // Entry produced by the ID instruction; a stalled, bubbled or flushed
  // slot enters EX as an empty entry.
  always_comb begin
    sb_new = '0;
    if (issue) begin
      sb_new.v  = id_valid & id_reg_write;
      sb_new.rd = REG_AW_MAX'(id_rd);
      sb_new.ld = id_mem_read;
    end
  end

  // Advance the writer pipeline every clock; the oldest entry drops off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb <= '0;
    end else begin
      sb[0] <= sb_new;
      for (int k = 1; k < PIPE_DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_match
    assign match[k] = sb[k].v & ((id_uses_rs & (rs_x == sb[k].rd)) |
                                 (id_uses_rt & (rt_x == sb[k].rd)));
  end

`ifdef FORWARD_EN
  // Forwarding covers everything but a load whose data is not yet read.
  assign hazard = id_valid & match[0] & sb[0].ld;
`else
  // No forwarding: wait until the writer has retired from WB.
  assign hazard = id_valid & (|match);
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and control-flow sequencer beside ID.
// Drives PC enable, IF/ID write/flush, ID/EX bubble and a saturating
// stall counter. Optional macro: FORWARD_EN (load-use-only hazards).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hif
);

  state_e           state_q, state_d;
  logic             hazard, taken, issue, stall;
  logic [CNT_W-1:0] cnt_q;

  assign taken = calc_taken(hif.ex_valid, hif.ex_branch_z, hif.ex_branch_n,
                            hif.ex_jump, hif.ex_jump_m, hif.ex_zero,
                            hif.ex_neg);

  hazard_scoreboard #(
    .REG_AW     (REG_AW),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .issue        (issue),
    .id_valid     (hif.id_valid),
    .id_rs        (hif.id_rs),
    .id_rt        (hif.id_rt),
    .id_uses_rs   (hif.id_uses_rs),
    .id_uses_rt   (hif.id_uses_rt),
    .id_rd        (hif.id_rd),
    .id_reg_write (hif.id_reg_write),
    .id_mem_read  (hif.id_mem_read),
    .hazard       (hazard)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state and control decode; redirect wins over a stall.
  always_comb begin
    state_d         = state_q;
    hif.pc_write    = 1'b1;
    hif.ifid_write  = 1'b1;
    hif.ifid_flush  = 1'b0;
    hif.idex_bubble = 1'b0;
    issue           = 1'b0;
    stall           = 1'b0;
    if (rst) begin
      hif.pc_write    = 1'b0;
      hif.ifid_write  = 1'b0;
      hif.ifid_flush  = 1'b1;
      hif.idex_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (taken) begin
            hif.ifid_flush  = 1'b1;
            hif.idex_bubble = 1'b1;
            // Memory-indirect target lands a cycle later: hold PC once.
            if (hif.ex_jump_m) begin
              hif.pc_write = 1'b0;
              state_d      = JMWAIT;
            end
          end else if (hazard) begin
            hif.pc_write    = 1'b0;
            hif.ifid_write  = 1'b0;
            hif.idex_bubble = 1'b1;
            stall           = 1'b1;
          end else begin
            issue = 1'b1;
          end
        end
        JMWAIT: begin
          hif.ifid_flush  = 1'b1;
          hif.idex_bubble = 1'b1;
          state_d         = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating count of hazard-stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt_q <= '0;
    else if (stall && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign hif.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + random checks of hazard_ctrl against an
// in-flight-writer list model. Two DUTs share stimulus: CNT_W=16 and CNT_W=4.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int AW = 6;
  localparam int PD = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(AW), .CNT_W(16)) hif ();
  hazard_ctrl_if #(.REG_AW(AW), .CNT_W(4))  hif4 ();

  hazard_ctrl #(.REG_AW(AW), .PIPE_DEPTH(PD), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hif(hif)
  );
  hazard_ctrl #(.REG_AW(AW), .PIPE_DEPTH(PD), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .hif(hif4)
  );

  assign hif4.id_valid     = hif.id_valid;
  assign hif4.id_rs        = hif.id_rs;
  assign hif4.id_rt        = hif.id_rt;
  assign hif4.id_uses_rs   = hif.id_uses_rs;
  assign hif4.id_uses_rt   = hif.id_uses_rt;
  assign hif4.id_rd        = hif.id_rd;
  assign hif4.id_reg_write = hif.id_reg_write;
  assign hif4.id_mem_read  = hif.id_mem_read;
  assign hif4.ex_valid     = hif.ex_valid;
  assign hif4.ex_branch_z  = hif.ex_branch_z;
  assign hif4.ex_branch_n  = hif.ex_branch_n;
  assign hif4.ex_jump      = hif.ex_jump;
  assign hif4.ex_jump_m    = hif.ex_jump_m;
  assign hif4.ex_zero      = hif.ex_zero;
  assign hif4.ex_neg       = hif.ex_neg;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Each issued register writer is remembered with its age (1 = in EX,
  // PD = in WB); it stops mattering once its age exceeds PD.
  typedef struct {
    int unsigned rd;
    bit          ld;
    int          age;
  } wr_t;
  wr_t inflight[$];
  bit  m_jm;
  int  m_cnt16, m_cnt4;
  bit [3:0] e_ctl;  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  bit  e_stall, e_issue, e_next_jm;

  function automatic bit m_hazard();
    bit dep;
    if (hif.id_valid !== 1'b1) return 1'b0;
    foreach (inflight[i]) begin
      dep = (hif.id_uses_rs && hif.id_rs == inflight[i].rd) ||
            (hif.id_uses_rt && hif.id_rt == inflight[i].rd);
`ifdef FORWARD_EN
      dep = dep && inflight[i].age == 1 && inflight[i].ld;
`endif
      if (dep) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_reset();
    inflight.delete();
    m_jm = 0; m_cnt16 = 0; m_cnt4 = 0;
  endtask

  task automatic m_eval();
    bit t;
    e_stall = 0; e_issue = 0; e_next_jm = 0;
    t = hif.ex_valid && ((hif.ex_branch_z && hif.ex_zero) ||
        (hif.ex_branch_n && hif.ex_neg) || hif.ex_jump || hif.ex_jump_m);
    if (rst)              e_ctl = 4'b0011;
    else if (m_jm)        e_ctl = 4'b1111;
    else if (t) begin
      e_ctl     = hif.ex_jump_m ? 4'b0111 : 4'b1111;
      e_next_jm = hif.ex_jump_m;
    end else if (m_hazard()) begin
      e_ctl = 4'b0001; e_stall = 1;
    end else begin
      e_ctl = 4'b1100; e_issue = 1;
    end
  endtask

  task automatic m_step();
    wr_t w;
    if (rst) begin m_reset(); return; end
    foreach (inflight[i]) inflight[i].age++;
    while (inflight.size() > 0 && inflight[0].age > PD) void'(inflight.pop_front());
    if (e_issue && hif.id_valid && hif.id_reg_write) begin
      w.rd = hif.id_rd; w.ld = hif.id_mem_read; w.age = 1;
      inflight.push_back(w);
    end
    m_jm = e_next_jm;
    if (e_stall) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15)     m_cnt4++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_id(bit v, int rs, bit urs, int rt, bit urt, int rd, bit rw, bit ld);
    hif.id_valid = v; hif.id_rs = AW'(rs); hif.id_uses_rs = urs;
    hif.id_rt = AW'(rt); hif.id_uses_rt = urt; hif.id_rd = AW'(rd);
    hif.id_reg_write = rw; hif.id_mem_read = ld;
  endtask

  task automatic set_ex(bit v, bit bz, bit bn, bit j, bit jm, bit z, bit n);
    hif.ex_valid = v; hif.ex_branch_z = bz; hif.ex_branch_n = bn;
    hif.ex_jump = j; hif.ex_jump_m = jm; hif.ex_zero = z; hif.ex_neg = n;
  endtask

  task automatic settle();
    @(negedge clk);
    m_eval();
  endtask

  task automatic adv();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_ex(0, 0, 0, 0, 0, 0, 0);
    repeat (PD + 1) begin settle(); adv(); end
  endtask

  function automatic bit [3:0] ctl();
    return {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_bubble};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    set_id(1, 5, 1, 5, 1, 5, 1, 1);
    set_ex(1, 0, 0, 1, 0, 0, 0);
    m_reset();
    repeat (2) begin settle(); adv(); end
    settle();
    checks++;
    if (ctl() !== 4'b0011) begin
      errors++; $display("FAIL reset_ctl got %b exp %b", ctl(), 4'b0011);
    end
    checks++;
    if (hif.stall_cnt !== 16'd0 || hif4.stall_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0", hif.stall_cnt, hif4.stall_cnt);
    end
    adv();
    rst = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_ex(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_independent();
    drain();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_id(1, 0, 0, 0, 0, 5, 1, 0);
      else        set_id(1, 6, 1, 7, 1, 8 + i, 1, 0);
      settle();
      checks++;
      if (ctl() !== e_ctl || ctl() !== 4'b1100) begin
        errors++; $display("FAIL indep_ctl[%0d] got %b exp %b", i, ctl(), 4'b1100);
      end
      adv();
    end
    checks++;
    if (hif.stall_cnt !== 16'(m_cnt16) || m_cnt16 != 0) begin
      errors++; $display("FAIL indep_cnt got %0d exp 0", hif.stall_cnt);
    end
  endtask

  // Writer followed by a dependent reader; count cycles the reader is held.
  task automatic test_dep(string name, bit load, int exp_stalls);
    int stalls = 0;
    bit done = 0;
    int base;
    drain();
    base = m_cnt16;
    set_id(1, 0, 0, 0, 0, load ? 9 : 5, 1, load);
    settle(); adv();
    if (load) set_id(1, 1, 1, 9, 1, 10, 1, 0);
    else      set_id(1, 5, 1, 2, 0, 10, 1, 0);
    for (int c = 0; c < 8 && !done; c++) begin
      settle();
      checks++;
      if (ctl() !== e_ctl) begin
        errors++; $display("FAIL %s_ctl[%0d] got %b exp %b", name, c, ctl(), e_ctl);
      end
      if (hif.pc_write === 1'b0 && hif.idex_bubble === 1'b1) stalls++;
      done = e_issue;
      adv();
    end
    checks++;
    if (!done || stalls != exp_stalls) begin
      errors++; $display("FAIL %s_stalls got %0d exp %0d", name, stalls, exp_stalls);
    end
    checks++;
    if (hif.stall_cnt !== 16'(base + exp_stalls)) begin
      errors++; $display("FAIL %s_cnt got %0d exp %0d", name, hif.stall_cnt, base + exp_stalls);
    end
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_branch();
    int base;
    drain();
    base = m_cnt16;
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    settle(); adv();
    // reader of r5 (hazard in both builds) while a taken branch sits in EX
    set_id(1, 5, 1, 0, 0, 12, 1, 1);
    set_ex(1, 1, 0, 0, 0, 1, 0);
    settle();
    checks++;
    if (ctl() !== 4'b1111 || e_ctl != 4'b1111) begin
      errors++; $display("FAIL branch_ctl got %b exp %b", ctl(), 4'b1111);
    end
    adv();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    set_id(1, 12, 1, 12, 1, 13, 0, 0);  // reads the flushed instruction's rd
    settle();
    checks++;
    if (ctl() !== 4'b1100) begin
      errors++; $display("FAIL branch_sb0 got %b exp %b", ctl(), 4'b1100);
    end
    checks++;
    if (hif.stall_cnt !== 16'(base)) begin
      errors++; $display("FAIL branch_cnt got %0d exp %0d", hif.stall_cnt, base);
    end
    adv();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_jump_m();
    bit [3:0] exp_seq [3];
    exp_seq[0] = 4'b0111; exp_seq[1] = 4'b1111; exp_seq[2] = 4'b1100;
    drain();
    set_id(1, 0, 0, 0, 0, 3, 1, 0);
    settle(); adv();
    for (int c = 0; c < 3; c++) begin
      if (c < 2) set_ex(1, 0, 0, 0, 1, 0, 0);  // still asserted in JMWAIT: ignored
      else       set_ex(0, 0, 0, 0, 0, 0, 0);
      if (c == 1) set_id(1, 3, 1, 3, 1, 4, 1, 0); // hazard ignored in JMWAIT
      else        set_id(1, 20, 1, 21, 1, 22, 1, 0);
      settle();
      checks++;
      if (ctl() !== exp_seq[c] || e_ctl != exp_seq[c]) begin
        errors++; $display("FAIL jumpm_ctl[%0d] got %b exp %b", c, ctl(), exp_seq[c]);
      end
      adv();
    end
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    drain();
    set_id(1, 0, 0, 0, 0, 20, 1, 1);
    settle(); adv();
    set_id(1, 0, 0, 0, 0, 0, 0, 0);
    set_ex(1, 0, 0, 0, 1, 0, 0);
    settle(); adv();             // now in JMWAIT, r20 in the scoreboard
    set_ex(0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    #1;
    checks++;
    if (ctl() !== 4'b0011) begin
      errors++; $display("FAIL rstmid_ctl got %b exp %b", ctl(), 4'b0011);
    end
    m_reset();
    settle(); adv();
    rst = 0;
    set_id(1, 20, 1, 20, 1, 21, 1, 0);
    settle();
    checks++;
    if (ctl() !== 4'b1100 || e_ctl != 4'b1100) begin
      errors++; $display("FAIL rstmid_run got %b exp %b", ctl(), 4'b1100);
    end
    checks++;
    if (hif.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid_cnt got %0d exp 0", hif.stall_cnt);
    end
    adv();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    int stalls = 0;
    for (int it = 0; it < 40 && stalls < 20; it++) begin
      set_id(1, 0, 0, 0, 0, 9, 1, 1);
      settle(); adv();
      set_id(1, 9, 1, 0, 0, 0, 0, 0);
      for (int c = 0; c < 5; c++) begin
        settle();
        checks++;
        if (ctl() !== e_ctl) begin
          errors++; $display("FAIL sat_ctl got %b exp %b", ctl(), e_ctl);
        end
        if (e_stall) stalls++;
        adv();
        if (!e_stall) break;
      end
    end
    checks++;
    if (stalls < 20 || hif4.stall_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_cnt4 got %0d exp 15 (stalls %0d)", hif4.stall_cnt, stalls);
    end
    checks++;
    if (hif.stall_cnt !== 16'(m_cnt16)) begin
      errors++; $display("FAIL sat_cnt16 got %0d exp %0d", hif.stall_cnt, m_cnt16);
    end
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      set_ex($urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 1), $urandom_range(0, 1));
      settle();
      checks++;
      if (ctl() !== e_ctl || hif.stall_cnt !== 16'(m_cnt16) || hif4.stall_cnt !== 4'(m_cnt4)) begin
        errors++;
        $display("FAIL rand[%0d] got ctl %b cnt %0d/%0d exp ctl %b cnt %0d/%0d",
                 i, ctl(), hif.stall_cnt, hif4.stall_cnt, e_ctl, m_cnt16, m_cnt4);
      end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_independent();
`ifdef FORWARD_EN
    test_dep("raw", 0, 0);
    test_dep("loaduse", 1, 1);
`else
    test_dep("raw", 0, 3);
    test_dep("loaduse", 1, 3);
`endif
    test_branch();
    test_jump_m();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
